// File: rtl/mem_led_pkg.sv
// Shared definitions for the LED pattern memory: geometry, writer FSM states and
// the {page, offset} address map used by both the player and the writer.
package mem_led_pkg;

    localparam int DATA_W     = 8;
    localparam int OFS_W      = 4;
    localparam int PAGE_DEPTH = 1 << OFS_W;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_LOAD  = 2'd1,
        WR_CLEAR = 2'd2,
        WR_DONE  = 2'd3
    } wr_state_t;

    // Page bit sits above the in-page offset; the player decodes the same way.
    function automatic logic [OFS_W:0] page_addr(input logic page, input logic [OFS_W-1:0] ofs);
        return {page, ofs};
    endfunction

endpackage

// File: rtl/mem_pattern_writer_if.sv
// Command, pattern-stream and memory-write signals of the pattern writer.
// master = pattern source side, slave = the writer block.
interface mem_pattern_writer_if #(
    parameter int DATA_W = mem_led_pkg::DATA_W,
    parameter int OFS_W  = mem_led_pkg::OFS_W
);
    logic              page_sel;
    logic              start;
    logic              clear;
    logic              abort;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [OFS_W:0]    mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              busy;
    logic              done;
    logic [OFS_W:0]    wr_count;

    modport master (
        output page_sel, start, clear, abort, din, din_valid,
        input  din_ready, mem_addr, mem_data, mem_wren, busy, done, wr_count
    );

    modport slave (
        input  page_sel, start, clear, abort, din, din_valid,
        output din_ready, mem_addr, mem_data, mem_wren, busy, done, wr_count
    );
endinterface

// File: rtl/wr_addr_gen.sv
// In-page offset counter for the pattern writer: synchronous clear, increment,
// and a flag marking the last offset of the page.
module wr_addr_gen #(
    parameter int OFS_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [OFS_W-1:0] ofs,
    output logic             last
);
    localparam logic [OFS_W-1:0] OFS_ONE = {{(OFS_W-1){1'b0}}, 1'b1};

    logic [OFS_W-1:0] ofs_q, ofs_d;

    always_comb begin
        ofs_d = ofs_q;
        if (clr)
            ofs_d = '0;
        else if (inc)
            ofs_d = ofs_q + OFS_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ofs_q <= '0;
        else
            ofs_q <= ofs_d;
    end

    assign ofs  = ofs_q;
    assign last = &ofs_q;
endmodule

// File: rtl/mem_pattern_writer.sv
// Loads or zero-fills one 16-entry page of the LED pattern memory. All memory
// write outputs are registered; a session always ends with a one-cycle DONE.
module mem_pattern_writer #(
    parameter int DATA_W = mem_led_pkg::DATA_W,
    parameter int OFS_W  = mem_led_pkg::OFS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_pattern_writer_if.slave  bus
);
    import mem_led_pkg::*;

    localparam logic [OFS_W:0] CNT_ONE = {{OFS_W{1'b0}}, 1'b1};

    wr_state_t         state_q, state_d;
    logic              page_q, page_d;
    logic [OFS_W:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic [OFS_W:0]    cnt_q, cnt_d;

    logic [OFS_W-1:0]  ofs;
    logic              ofs_last, ofs_clr, ofs_inc;
    logic              wr;
    logic [DATA_W-1:0] wr_data;

    wr_addr_gen #(.OFS_W(OFS_W)) u_addr (
        .clk   (clk),
        .reset (reset),
        .clr   (ofs_clr),
        .inc   (ofs_inc),
        .ofs   (ofs),
        .last  (ofs_last)
    );

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        cnt_d      = cnt_q;
        ofs_clr    = 1'b0;
        ofs_inc    = 1'b0;
        wr         = 1'b0;
        wr_data    = '0;

        case (state_q)
            WR_IDLE: begin
                // clear has priority when both commands arrive together
                if (bus.clear || bus.start) begin
                    state_d = bus.clear ? WR_CLEAR : WR_LOAD;
                    page_d  = bus.page_sel;
                    cnt_d   = '0;
                    ofs_clr = 1'b1;
                end
            end
            WR_LOAD: begin
                if (bus.din_valid) begin
                    wr      = 1'b1;
                    wr_data = bus.din;
                    if (ofs_last)
                        state_d = WR_DONE;
                end
                // a word arriving with abort is still written
                if (bus.abort)
                    state_d = WR_DONE;
            end
            WR_CLEAR: begin
                wr = 1'b1;
                if (ofs_last)
                    state_d = WR_DONE;
            end
            WR_DONE:  state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase

        if (wr) begin
            mem_addr_d = page_addr(page_q, ofs);
            mem_data_d = wr_data;
            mem_wren_d = 1'b1;
            cnt_d      = cnt_q + CNT_ONE;
            ofs_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WR_IDLE;
            page_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.din_ready = (state_q == WR_LOAD);
    assign bus.busy      = (state_q != WR_IDLE);
    assign bus.done      = (state_q == WR_DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_wren  = mem_wren_q;
    assign bus.wr_count  = cnt_q;
endmodule

// File: tb/tb_mem_pattern_writer.sv
// Bench for mem_pattern_writer: table of session vectors, reset corner cases,
// then randomized sessions checked against a write-list model.
module tb_mem_pattern_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    mem_pattern_writer_if bus ();

    mem_pattern_writer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe with the cycle it was seen in
    logic [12:0] wq[$];
    int          wcyc[$];
    int          done_cnt = 0;
    int          busy_cyc = 0;
    logic        last_done_wren = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            wq.push_back({bus.mem_addr, bus.mem_data});
            wcyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_done_wren = bus.mem_wren;
        end
        if (bus.busy === 1'b1) busy_cyc++;
    end

    typedef struct {
        bit is_clear;
        bit both;
        bit page;
        int nwords;
        int abort_idx;
        int gap;
        bit poke;
        bit cnt_data;
        int exp_writes;
        int exp_count;
        bit exp_done_wren;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Number of words a session writes, from the session description alone
    function automatic int model_writes(bit cl, int nw, int ai);
        if (cl) return 16;
        if (ai >= 0 && ai < nw) return ai + 1;
        return nw;
    endfunction

    task automatic run_session(input string tag, input bit is_clear, input bit both, input bit page,
                               input int nwords, input int abort_idx, input int gap, input bit rnd_gap,
                               input bit poke, input bit cnt_data, input int exp_writes,
                               input int exp_count, input bit exp_done_wren);
        logic [7:0]  w[16];
        logic [12:0] e;
        int base, dbase, bbase, k0, nhs, t, g;
        for (int i = 0; i < 16; i++) w[i] = cnt_data ? 8'(i + 1) : 8'($urandom);
        base  = wq.size();
        dbase = done_cnt;
        bbase = busy_cyc;

        bus.page_sel = page;
        bus.clear    = is_clear;
        bus.start    = !is_clear || both;
        tick();
        k0 = cyc;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        bus.page_sel = 1'($urandom);
        chk({tag, " din_ready"}, 32'(bus.din_ready), 32'(!is_clear));

        if (!is_clear) begin
            nhs = (abort_idx >= 0 && abort_idx < nwords) ? abort_idx + 1 : nwords;
            for (int i = 0; i < nhs; i++) begin
                g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
                repeat (g) begin
                    bus.din = 8'($urandom);
                    tick();
                end
                bus.din       = w[i];
                bus.din_valid = 1'b1;
                bus.abort     = (i == abort_idx);
                if (poke && i == 2) begin
                    bus.start    = 1'b1;
                    bus.page_sel = ~page;
                end
                tick();
                bus.din_valid = 1'b0;
                bus.abort     = 1'b0;
                bus.start     = 1'b0;
            end
            if (abort_idx >= nwords) begin
                repeat (gap) tick();
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
            end
        end

        t = 0;
        while (bus.busy !== 1'b0 && t < 40) begin
            if (poke && is_clear && t == 3) begin
                bus.start    = 1'b1;
                bus.page_sel = ~page;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            t++;
        end
        bus.start = 1'b0;
        chk({tag, " ends_in_time"}, 32'(t < 40), 32'd1);
        tick();

        chk({tag, " n_writes"}, 32'(wq.size() - base), 32'(exp_writes));
        for (int i = 0; i < exp_writes && base + i < wq.size(); i++) begin
            e = {page, 4'(i), is_clear ? 8'h00 : w[i]};
            chk($sformatf("%s write%0d addr_data", tag, i), 32'(wq[base + i]), 32'(e));
            if (is_clear || (gap == 0 && !rnd_gap))
                chk($sformatf("%s write%0d cycle", tag, i), 32'(wcyc[base + i]), 32'(k0 + 1 + i));
        end
        chk({tag, " wr_count"}, 32'(bus.wr_count), 32'(exp_count));
        chk({tag, " done_pulses"}, 32'(done_cnt - dbase), 32'd1);
        chk({tag, " done_with_wren"}, 32'(last_done_wren), 32'(exp_done_wren));
        if (is_clear)
            chk({tag, " busy_cycles"}, 32'(busy_cyc - bbase), 32'd17);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, " mem_data"},  32'(bus.mem_data),  32'd0);
        chk({tag, " mem_wren"},  32'(bus.mem_wren),  32'd0);
        chk({tag, " busy"},      32'(bus.busy),      32'd0);
        chk({tag, " done"},      32'(bus.done),      32'd0);
        chk({tag, " wr_count"},  32'(bus.wr_count),  32'd0);
        chk({tag, " din_ready"}, 32'(bus.din_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, mode, nw, ai, ew;
        bit cl, pg, dw;

        bus.page_sel  = 1'b0;
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.abort     = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;

        //                is_clear both page nwords abort gap poke cnt  ew  ec  dw
        vecs[0] = '{0, 0, 1, 16, -1, 0, 0, 1, 16, 16, 1};
        vecs[1] = '{1, 0, 0,  0, -1, 0, 0, 0, 16, 16, 1};
        vecs[2] = '{0, 0, 0, 16, -1, 1, 0, 0, 16, 16, 1};
        vecs[3] = '{0, 0, 1,  6,  5, 0, 0, 1,  6,  6, 1};
        vecs[4] = '{1, 1, 1,  0, -1, 0, 0, 0, 16, 16, 1};
        vecs[5] = '{1, 0, 0,  0, -1, 0, 1, 0, 16, 16, 1};
        vecs[6] = '{0, 0, 1, 16, -1, 0, 1, 0, 16, 16, 1};
        vecs[7] = '{0, 0, 0,  0,  0, 0, 0, 0,  0,  0, 0};
        vecs[8] = '{0, 0, 1,  3,  3, 1, 0, 0,  3,  3, 0};

        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 9; v++)
            run_session($sformatf("vec%0d", v), vecs[v].is_clear, vecs[v].both, vecs[v].page,
                        vecs[v].nwords, vecs[v].abort_idx, vecs[v].gap, 1'b0, vecs[v].poke,
                        vecs[v].cnt_data, vecs[v].exp_writes, vecs[v].exp_count,
                        vecs[v].exp_done_wren);

        // Reset in the middle of a load after three writes
        b = wq.size();
        bus.page_sel = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.din       = 8'(8'hA0 + i);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        tick();
        chk("midrst writes_before", 32'(wq.size() - b), 32'd3);
        chk("midrst wr_count_before", 32'(bus.wr_count), 32'd3);
        chk("midrst last_write", 32'(wq[wq.size() - 1]), 32'({5'd18, 8'hA2}));
        b = wq.size();
        bus.din_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) tick();
        bus.din_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("midrst no_strobe", 32'(wq.size() - b), 32'd0);
        run_session("post_reset", 1'b0, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b1);

        // Randomized sessions against the write-list model
        for (int r = 0; r < 24; r++) begin
            mode = int'($urandom_range(0, 3));
            pg   = 1'($urandom);
            cl   = (mode == 3);
            nw   = 0;
            ai   = -1;
            case (mode)
                0: nw = 16;
                1: begin
                    nw = int'($urandom_range(1, 16));
                    ai = int'($urandom_range(0, nw - 1));
                end
                2: begin
                    nw = int'($urandom_range(0, 15));
                    ai = nw;
                end
                default: ;
            endcase
            ew = model_writes(cl, nw, ai);
            dw = (mode != 2);
            run_session($sformatf("rnd%0d", r), cl, cl && ($urandom_range(0, 1) == 1), pg, nw, ai,
                        0, 1'b1, 1'b0, 1'b0, ew, ew, dw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
